ram_sorter: RTL and testbench
=============================

RAM_SORTER -- requirements
Module: ram_sorter

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset, sampled on the clk rising edge.
REQ-002 SHALL have port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port: start  input  1  level request to sort, held high until done is observed.
REQ-005 SHALL have port: wr_en  input  1  load-write strobe, honoured only in IDLE.
REQ-006 SHALL have port: wr_addr  input  5  load-write address 0..31.
REQ-007 SHALL have port: wr_data  input  8  load-write data, unsigned.
REQ-008 SHALL have port: rd_addr  input  5  read address for the downstream search stage.
REQ-009 SHALL have port: rd_data  output  8  registered contents of mem[rd_addr].
REQ-010 SHALL have port: busy  output  1  high while in SORT.
REQ-011 SHALL have port: done  output  1  high while in DONE, meaning the contents are sorted ascending.

Function
REQ-012 SHALL hold 32x8 internal register storage mem[0..31].
REQ-013 SHALL have three FSM states: IDLE, SORT, DONE.
REQ-014 SHALL transition IDLE->SORT when start=1, and otherwise stay in IDLE.
REQ-015 SHALL transition SORT->DONE at the end of a pass with no swaps, or at the end of the pass with limit=1.
REQ-016 SHALL stay in DONE while start=1, and SHALL transition DONE->IDLE when start=0.
REQ-017 SHALL, in IDLE with wr_en=1, write mem[wr_addr]<=wr_data at the clock edge; back-to-back writes to the same address resolve as last write wins.
REQ-018 SHALL ignore wr_en in SORT and DONE, leaving mem unchanged.
REQ-019 SHALL ignore start toggles in SORT, and the sort SHALL run to completion.
REQ-020 SHALL update rd_data<=mem[rd_addr] every cycle in all states (1-cycle read latency); a read in the same cycle as a write or swap to that address returns the pre-update value.
REQ-021 SHALL perform bubble sort: index i (5 bits) and limit (5 bits) are set to i=0, limit=31 and the swapped flag is cleared on the IDLE->SORT edge.
REQ-022 SHALL, each SORT cycle, compare mem[i] and mem[i+1] as unsigned; if mem[i]>mem[i+1] strictly, it SHALL swap both in that cycle and set swapped; equal values are not swapped.
REQ-023 SHALL increment i when i<limit-1.
REQ-024 SHALL end the pass at i=limit-1: if swapped (including this cycle's compare) and limit>1, it SHALL set limit<=limit-1, i<=0 and clear swapped; otherwise it SHALL enter DONE.
REQ-025 SHALL complete already-sorted input in 31 SORT cycles, with done asserted on the 32nd edge after start was sampled.
REQ-026 SHALL complete the worst case (strictly descending input) in 31+30+...+1 = 496 SORT cycles.
REQ-027 SHALL drive busy and done combinationally from the state: busy=(state==SORT), done=(state==DONE).
REQ-028 SHALL never drive i+1 beyond 31, so no wrap-around compare occurs.

Reset
REQ-029 SHALL, on reset, set state=IDLE, i=0, limit=31, swapped=0, every mem entry=0, rd_data=0, busy=0, done=0.
REQ-030 SHALL give reset priority over all other inputs, including mid-SORT; a reset during SORT abandons the partial sort and clears mem.
REQ-031 SHALL not have start, wr_en or any other input affect state in the cycle reset is high.

Verification
REQ-032 SHALL be verified with: load mem[k]=k for k=0..31, start=1 -> busy for 31 cycles, done=1, mem unchanged, rd_addr=5 gives rd_data=5 one cycle later.
REQ-033 SHALL be verified with: load mem[k]=31-k, start=1 -> done after 496 SORT cycles, mem[k]=k for all k.
REQ-034 SHALL be verified with: load mem[0]=200, mem[1..31]=7, start=1 -> final mem[0..30]=7 and mem[31]=200; mem[0..30] keep the input value 7 (equal values never swapped).
REQ-035 SHALL be verified with: wr_en=1 during SORT writing 8'hFF to address 0 -> ignored; and start deasserted mid-SORT -> sort still completes, then DONE->IDLE on the next edge.
REQ-036 SHALL be verified with: reset pulse at SORT cycle 10 of a descending load -> next cycle state=IDLE, busy=0, done=0, every mem entry reads 0.
REQ-037 SHALL be verified with: done high with start held 5 cycles -> done stays 1; start=0 -> done=0 next cycle; new writes are then accepted.

Source files
------------

// File: rtl/ram_sorter.sv
// In-place bubble sort over a 32x8 register array, loaded while idle and
// read back through a registered port by the downstream search stage.
module ram_sorter (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] mem [32];
    logic [4:0] i;
    logic [4:0] limit;
    logic       swapped;

    logic [4:0] ip1;
    logic       do_swap;
    logic       end_pass;
    logic       another_pass;

    // i never exceeds limit-1 <= 30, so ip1 stays within 1..31.
    assign ip1          = i + 5'd1;
    assign do_swap      = mem[i] > mem[ip1];
    assign end_pass     = (i == limit - 5'd1);
    assign another_pass = (swapped || do_swap) && (limit > 5'd1);

    always_comb begin
        // NOTE: next state gets a default before the case so no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SORT;
            SORT:    if (end_pass && !another_pass) state_next = DONE;
            DONE:    if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the array is reset explicitly because a reset must leave the
            // contents all-zero; this keeps it in flops rather than a RAM macro.
            // NOTE: non-blocking assignments throughout so every register sees
            // pre-edge values, which also gives read-before-write on rd_data.
            state   <= IDLE;
            i       <= 5'd0;
            limit   <= 5'd31;
            swapped <= 1'b0;
            rd_data <= 8'd0;
            for (int k = 0; k < 32; k++) mem[k] <= 8'd0;
        end else begin
            state   <= state_next;
            rd_data <= mem[rd_addr];
            case (state)
                IDLE: begin
                    if (wr_en) mem[wr_addr] <= wr_data;
                    if (start) begin
                        i       <= 5'd0;
                        limit   <= 5'd31;
                        swapped <= 1'b0;
                    end
                end
                SORT: begin
                    if (do_swap) begin
                        mem[i]   <= mem[ip1];
                        mem[ip1] <= mem[i];
                    end
                    if (end_pass) begin
                        if (another_pass) begin
                            limit   <= limit - 5'd1;
                            i       <= 5'd0;
                            swapped <= 1'b0;
                        end else begin
                            swapped <= swapped || do_swap;
                        end
                    end else begin
                        i       <= ip1;
                        swapped <= swapped || do_swap;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == SORT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_ram_sorter.sv
// Directed bench for ram_sorter: sorted, descending, duplicate-heavy loads,
// ignored writes/start during SORT, mid-sort reset and DONE handshake.
module tb_ram_sorter;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_sorter dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic write(input logic [4:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [4:0] a, input logic [7:0] exp);
        rd_addr = a;
        tick();
        check($sformatf("%s[%0d]", tag, a), rd_data, exp);
    endtask

    task automatic load_desc();
        for (int k = 0; k < 32; k++) write(5'(k), 8'(31 - k));
    endtask

    // Raises start, waits for busy to fall (bounded), returns SORT cycle count.
    task automatic run_sort(output int cycles);
        start = 1'b1;
        tick();
        cycles = 0;
        while (busy && cycles < 2000) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        int cyc;
        reset   = 1'b0;
        start   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 5'd0;
        wr_data = 8'd0;
        rd_addr = 5'd0;

        // Reset state
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd", rd_data, 0);

        // Already sorted: 31 cycles, contents unchanged, DONE held with start
        for (int k = 0; k < 32; k++) write(5'(k), 8'(k));
        run_sort(cyc);
        check("sorted_cycles", cyc, 31);
        check("sorted_done", done, 1);
        for (int n = 0; n < 5; n++) begin
            tick();
            check("done_hold", done, 1);
        end
        read_chk("sorted_rd5", 5'd5, 8'd5);
        for (int k = 0; k < 32; k++) read_chk("sorted", 5'(k), 8'(k));
        start = 1'b0;
        tick();
        check("done_release", done, 0);
        check("idle_busy", busy, 0);
        write(5'd3, 8'd99);
        read_chk("idle_wr", 5'd3, 8'd99);
        write(5'd7, 8'd1);
        write(5'd7, 8'd2);
        read_chk("last_wins", 5'd7, 8'd2);

        // Strictly descending: worst case 496 cycles
        do_reset();
        load_desc();
        run_sort(cyc);
        check("desc_cycles", cyc, 496);
        check("desc_done", done, 1);
        for (int k = 0; k < 32; k++) read_chk("desc", 5'(k), 8'(k));
        start = 1'b0;
        tick();

        // One large value followed by equal values: two passes, 31+30 cycles
        do_reset();
        write(5'd0, 8'd200);
        for (int k = 1; k < 32; k++) write(5'(k), 8'd7);
        run_sort(cyc);
        check("dup_cycles", cyc, 61);
        for (int k = 0; k < 31; k++) read_chk("dup", 5'(k), 8'd7);
        read_chk("dup", 5'd31, 8'd200);
        start = 1'b0;
        tick();

        // Write and start drop during SORT are ignored
        do_reset();
        load_desc();
        start = 1'b1;
        tick();
        start   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 5'd0;
        wr_data = 8'hFF;
        tick();
        cyc = 1;
        wr_en = 1'b0;
        check("ign_busy", busy, 1);
        while (busy && cyc < 2000) begin
            tick();
            cyc++;
        end
        check("ign_cycles", cyc, 496);
        check("ign_done", done, 1);
        tick();
        check("ign_to_idle", done, 0);
        check("ign_idle_busy", busy, 0);
        for (int k = 0; k < 32; k++) read_chk("ign", 5'(k), 8'(k));

        // Reset at SORT cycle 10 wins over a held start
        do_reset();
        load_desc();
        start = 1'b1;
        tick();
        repeat (10) tick();
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_rd", rd_data, 0);
        tick();
        check("mid_rst_stay_idle", busy, 0);
        for (int k = 0; k < 32; k++) read_chk("mid_rst", 5'(k), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
